arp_rx_parser: RTL
==================

# arp_rx_parser

Parses the ARP byte stream that the receive buffer delivers after the EtherType field: the 28-byte ARP body plus any Ethernet padding or FCS up to `tlast`. It validates the fixed header fields and the target protocol address, then presents the sender MAC/IP with a request/reply flag on a valid/ready result port. The ARP transmit/reply builder and the ARP cache consume that port. It sits directly downstream of the receive buffer's `arp_axis_*` output.

## Interface
Parameters:
- `CNT_WIDTH`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `local_mac_addr_in`  in  48  station MAC; quasi-static.
- `local_ip_addr_in`  in  32  station IPv4 address; quasi-static.
- `arp_axis_tdata_in`  in  8  ARP stream byte.
- `arp_axis_tvalid_in`  in  1  byte valid.
- `arp_axis_tlast_in`  in  1  last byte of frame.
- `arp_axis_tready_o`  out  1  parser can accept a byte.
- `result_valid_o`  out  1  a parsed ARP result is held.
- `result_ready_in`  in  1  consumer accepts the result.
- `result_is_reply_o`  out  1  1 = OPER 2 (reply), 0 = OPER 1 (request).
- `sender_mac_o`  out  48  SHA field.
- `sender_ip_o`  out  32  SPA field.
- `rx_ok_cnt_o`  out  CNT_WIDTH  count of frames accepted as results.
- `rx_err_cnt_o`  out  CNT_WIDTH  count of malformed or runt frames.

## Operation
- A beat is accepted when `arp_axis_tvalid_in && arp_axis_tready_o`. Cycles where `tvalid` is low are ignored and all counters hold.
- `byte_cnt` is 5 bits. It increments on each accepted beat and saturates at 28.
- Byte offsets:
  - 0–1 HTYPE, must be 0x0001.
  - 2–3 PTYPE, must be 0x0800.
  - 4 HLEN, must be 6.
  - 5 PLEN, must be 4.
  - 6–7 OPER.
  - 8–13 SHA.
  - 14–17 SPA.
  - 18–23 THA.
  - 24–27 TPA.
- Multi-byte fields are big-endian. Each is shifted into its own capture register as its bytes arrive.
- The `hdr_bad` flag is set when any of the following holds; it is cleared at the start of each frame:
  - a fixed field (HTYPE, PTYPE, HLEN, PLEN) mismatches;
  - OPER is not 1 or 2;
  - OPER is 2 and THA ≠ `local_mac_addr_in`.
- States:
  - IDLE: the first accepted beat is byte 0. Go to HDR, or to DRAIN if that beat also carries `tlast` (runt).
  - HDR: capture bytes 1–27.
    - `tlast` before byte 27: runt. Increment `rx_err_cnt_o`, go to IDLE.
    - Byte 27 with `tlast`: evaluate immediately.
    - Byte 27 without `tlast`: go to DRAIN.
  - DRAIN: discard padding until `tlast`, then evaluate. (The runt path reaching DRAIN from IDLE drops the frame on `tlast` and counts it as an error.)
  - Evaluate:
    - `hdr_bad`: increment `rx_err_cnt_o`, go to IDLE.
    - Otherwise TPA ≠ `local_ip_addr_in`: silent drop with no count, go to IDLE.
    - Otherwise: load the result registers, increment `rx_ok_cnt_o`, go to HOLD.
  - HOLD: `result_valid_o` = 1. On `result_ready_in` go to IDLE.
- `arp_axis_tready_o` = 1 in IDLE, HDR and DRAIN; 0 in HOLD.
- Counters wrap modulo 2^CNT_WIDTH.
- Result outputs are stable for the whole time `result_valid_o` is high.

## Timing
- Reset (asynchronous, on `reset_n` low):
  - state = IDLE;
  - `result_valid_o` = 0, `result_is_reply_o` = 0;
  - `sender_mac_o` = 0, `sender_ip_o` = 0;
  - both counters = 0, `byte_cnt` = 0;
  - `arp_axis_tready_o` = 1 once reset is released.
- Reset asserted mid-frame discards the partial frame. After release the next accepted byte is treated as byte 0.
- Latency: `result_valid_o` rises on the clock edge that accepts the `tlast` beat, so it is visible the cycle after that beat. The counter update happens on the same edge.
- Handshake completes on the edge where `result_valid_o && result_ready_in`:
  - `result_valid_o` falls on that edge;
  - `arp_axis_tready_o` is 1 from the next cycle;
  - a consumer holding `result_ready_in` high gives one cycle of HOLD.
- A beat presented during HOLD is not accepted, because `tready` is 0.
- Back-to-back frames: a new byte 0 can be accepted the cycle after HOLD exits, or the cycle after a drop at `tlast`.
- The address inputs are sampled at evaluate time only.

## Test plan
- Minimal request: 28-byte frame with `tlast` on byte 27, OPER=1, SHA=00:11:22:33:44:55, SPA=192.168.1.10, TPA=`local_ip`, `result_ready_in` held 1. Required:
  - `result_valid_o` high for one cycle, the cycle after `tlast`;
  - `result_is_reply_o`=0, `sender_mac_o`=0x001122334455, `sender_ip_o`=0xC0A8010A;
  - `rx_ok_cnt_o`=1.
- Padded reply: 28 bytes plus 18 bytes of padding, random `tvalid` gaps, OPER=2, THA=`local_mac`, ready held 0 for 5 cycles. Required:
  - `result_is_reply_o`=1;
  - `result_valid_o` and the outputs stable for 5 cycles;
  - `tready`=0 during HOLD;
  - exactly one count added to `rx_ok_cnt_o`.
- Foreign target: TPA=192.168.1.99 ≠ `local_ip`. Required: no result, both counters unchanged, `tready` stays 1.
- Malformed frames, run as separate frames: PTYPE=0x86DD; OPER=3; runt with `tlast` at byte 10. Required: `rx_err_cnt_o` advances by exactly 1 per frame (3 total), no result.
- Reset in the middle of byte 15 of a frame, then a valid request. Required:
  - all outputs are 0 during reset;
  - the following frame yields a correct result with `rx_ok_cnt_o`=1.
- Counter wrap, with CNT_WIDTH=4: 17 valid frames. Required: `rx_ok_cnt_o`=1.

Source files
------------

// File: rtl/arp_rx_parser.sv
// ARP receive parser: validates the 28-byte ARP body streamed after the EtherType,
// then holds sender MAC/IP and the request/reply flag on a valid/ready result port.
module arp_rx_parser #(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [47:0]          local_mac_addr_in,
   input  logic [31:0]          local_ip_addr_in,
   input  logic [7:0]           arp_axis_tdata_in,
   input  logic                 arp_axis_tvalid_in,
   input  logic                 arp_axis_tlast_in,
   output logic                 arp_axis_tready_o,
   output logic                 result_valid_o,
   input  logic                 result_ready_in,
   output logic                 result_is_reply_o,
   output logic [47:0]          sender_mac_o,
   output logic [31:0]          sender_ip_o,
   output logic [CNT_WIDTH-1:0] rx_ok_cnt_o,
   output logic [CNT_WIDTH-1:0] rx_err_cnt_o
);

   typedef enum logic [1:0] {StIdle, StHdr, StDrain, StHold} state_e;

   state_e               r_state;
   logic [4:0]           r_byte_cnt;
   logic                 r_hdr_bad;
   logic                 r_runt;
   logic [15:0]          r_oper;
   logic [47:0]          r_sha;
   logic [31:0]          r_spa;
   logic [47:0]          r_tha;
   logic [31:0]          r_tpa;
   logic                 r_result_valid;
   logic                 r_is_reply;
   logic [47:0]          r_sender_mac;
   logic [31:0]          r_sender_ip;
   logic [CNT_WIDTH-1:0] r_ok_cnt;
   logic [CNT_WIDTH-1:0] r_err_cnt;

   logic        w_beat;
   logic        w_fixed_bad;
   logic        w_bad;
   logic        w_eval;
   logic [31:0] w_tpa;

   // Held low during reset so every output reads 0 while reset_n is asserted.
   assign arp_axis_tready_o = (r_state != StHold) && reset_n;
   assign w_beat            = arp_axis_tvalid_in && arp_axis_tready_o;

   always_comb begin
      w_fixed_bad = 1'b0;
      unique case (r_byte_cnt)
         5'd0:    w_fixed_bad = (arp_axis_tdata_in != 8'h00);
         5'd1:    w_fixed_bad = (arp_axis_tdata_in != 8'h01);
         5'd2:    w_fixed_bad = (arp_axis_tdata_in != 8'h08);
         5'd3:    w_fixed_bad = (arp_axis_tdata_in != 8'h00);
         5'd4:    w_fixed_bad = (arp_axis_tdata_in != 8'h06);
         5'd5:    w_fixed_bad = (arp_axis_tdata_in != 8'h04);
         default: w_fixed_bad = 1'b0;
      endcase
   end

   // Evaluating on byte 27 itself needs its TPA byte folded in combinationally.
   assign w_tpa  = (r_state == StDrain) ? r_tpa : {r_tpa[23:0], arp_axis_tdata_in};
   assign w_bad  = r_hdr_bad || !((r_oper == 16'd1) || (r_oper == 16'd2)) ||
                   ((r_oper == 16'd2) && (r_tha != local_mac_addr_in));
   assign w_eval = w_beat && arp_axis_tlast_in &&
                   (((r_state == StHdr) && (r_byte_cnt == 5'd27)) ||
                    ((r_state == StDrain) && !r_runt));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= StIdle;
         r_byte_cnt     <= '0;
         r_hdr_bad      <= 1'b0;
         r_runt         <= 1'b0;
         r_oper         <= '0;
         r_sha          <= '0;
         r_spa          <= '0;
         r_tha          <= '0;
         r_tpa          <= '0;
         r_result_valid <= 1'b0;
         r_is_reply     <= 1'b0;
         r_sender_mac   <= '0;
         r_sender_ip    <= '0;
         r_ok_cnt       <= '0;
         r_err_cnt      <= '0;
      end else begin
         if (w_beat) begin
            if (r_byte_cnt != 5'd28) r_byte_cnt <= r_byte_cnt + 5'd1;
            r_hdr_bad <= (r_state == StIdle) ? w_fixed_bad : (r_hdr_bad || w_fixed_bad);
            if (r_byte_cnt >= 5'd6 && r_byte_cnt <= 5'd7)
               r_oper <= {r_oper[7:0], arp_axis_tdata_in};
            if (r_byte_cnt >= 5'd8 && r_byte_cnt <= 5'd13)
               r_sha <= {r_sha[39:0], arp_axis_tdata_in};
            if (r_byte_cnt >= 5'd14 && r_byte_cnt <= 5'd17)
               r_spa <= {r_spa[23:0], arp_axis_tdata_in};
            if (r_byte_cnt >= 5'd18 && r_byte_cnt <= 5'd23)
               r_tha <= {r_tha[39:0], arp_axis_tdata_in};
            if (r_byte_cnt >= 5'd24 && r_byte_cnt <= 5'd27)
               r_tpa <= {r_tpa[23:0], arp_axis_tdata_in};
         end

         unique case (r_state)
            StIdle: begin
               if (w_beat) begin
                  r_runt  <= arp_axis_tlast_in;
                  r_state <= arp_axis_tlast_in ? StDrain : StHdr;
               end
            end
            StHdr: begin
               if (w_beat && arp_axis_tlast_in && (r_byte_cnt < 5'd27)) begin
                  r_err_cnt  <= r_err_cnt + CNT_WIDTH'(1);
                  r_byte_cnt <= '0;
                  r_state    <= StIdle;
               end else if (w_beat && (r_byte_cnt == 5'd27) && !arp_axis_tlast_in) begin
                  r_state <= StDrain;
               end
            end
            StDrain: begin
               if (w_beat && arp_axis_tlast_in && r_runt) begin
                  r_err_cnt  <= r_err_cnt + CNT_WIDTH'(1);
                  r_byte_cnt <= '0;
                  r_state    <= StIdle;
               end
            end
            StHold: begin
               if (result_ready_in) begin
                  r_result_valid <= 1'b0;
                  r_state        <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase

         if (w_eval) begin
            r_byte_cnt <= '0;
            if (w_bad) begin
               r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
               r_state   <= StIdle;
            end else if (w_tpa != local_ip_addr_in) begin
               r_state <= StIdle;
            end else begin
               r_is_reply     <= (r_oper == 16'd2);
               r_sender_mac   <= r_sha;
               r_sender_ip    <= r_spa;
               r_result_valid <= 1'b1;
               r_ok_cnt       <= r_ok_cnt + CNT_WIDTH'(1);
               r_state        <= StHold;
            end
         end
      end
   end

   assign result_valid_o    = r_result_valid;
   assign result_is_reply_o = r_is_reply;
   assign sender_mac_o      = r_sender_mac;
   assign sender_ip_o       = r_sender_ip;
   assign rx_ok_cnt_o       = r_ok_cnt;
   assign rx_err_cnt_o      = r_err_cnt;

endmodule
